div1: RTL and testbench
=======================

Name: div1

Overview:
- Sequential unsigned divider using repeated subtraction. It is the inverse operation of the team's repeated-addition multiplier (mul1).
- Dividend and divisor are loaded over one shared data bus on consecutive cycles, following a start pulse.
- A single control FSM drives a small datapath. Results are held with done asserted until the next start.
- Used as a standalone arithmetic unit driven by a host FSM or testbench.

Parameters:
- WIDTH, 16, bit width of the dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a new division; sampled in IDLE and DONE.
- data_in  input  WIDTH  dividend in the cycle after start is sampled; divisor in the following cycle.
- quotient  output  WIDTH  registered quotient; valid while done=1.
- remainder  output  WIDTH  registered remainder; valid while done=1.
- busy  output  1  high in LDA, LDB and CALC.
- done  output  1  high only in DONE.
- div_by_zero  output  1  present only with DIV1_DBZ_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; internal registers R (remainder), D (divisor) and Q (quotient) all 0; busy=0, done=0, div_by_zero=0. Reset mid-operation aborts immediately with no partial results kept.
- All outputs are Moore outputs decoded from state or driven directly from registers. No combinational path from any input to any output.
- States, encoded 3 bits in the package:
  - IDLE: start=1 -> LDA; otherwise stay.
  - LDA: R <= data_in; -> LDB unconditionally.
  - LDB: D <= data_in; Q <= 0; -> CALC unconditionally.
  - CALC: evaluated in priority order each cycle:
    - D==0: Q <= all ones; R unchanged; set dbz flag; -> DONE.
    - R>=D: R <= R-D; Q <= Q+1; stay in CALC.
    - Otherwise -> DONE.
  - DONE: done=1; Q and R held. start=1 -> LDA, which clears done and the dbz flag. Otherwise stay.
- Latency: let start be sampled high in cycle N. CALC occupies Q_final+1 cycles (exactly 1 cycle for divide-by-zero). done rises in cycle N+4+Q_final.
- start asserted in LDA, LDB or CALC is ignored.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The comparator is unsigned, and R-D never underflows because it is only applied when R>=D.
  - Q cannot overflow, since Q_final <= dividend.
- Unused state encodings return to IDLE on the next clock with all control deasserted.

Optional Feature:
- Macro: DIV1_DBZ_EN.
- Defined: div_by_zero port exists. It is 1 in DONE when the divisor was 0, cleared on leaving DONE and on reset.
- Undefined: port absent. Divide-by-zero still terminates identically (Q all ones, R = dividend) with no flag.

Decomposition:
- Package div1_pkg: state constants IDLE, LDA, LDB, CALC, DONE (3-bit encoding) and the WIDTH default constant.
- One sub-module, div1_dp (datapath): R, D and Q registers, the >= comparator, the subtractor and the incrementer. It is driven by load/clear/step strobes from the FSM in div1, and returns ge and dz status signals.

Test Plan:
- 100/7: done rises in cycle N+18; quotient=14, remainder=2; busy high cycles N+1..N+17.
- 5/9: one CALC cycle; done in cycle N+4; quotient=0, remainder=5.
- 9/0 (WIDTH=16): done in cycle N+4; quotient=16'hFFFF, remainder=9. div_by_zero=1 with DIV1_DBZ_EN, port absent without it.
- 65535/1 (WIDTH=16): quotient=65535, remainder=0, done in cycle N+65539. Then start=1 in DONE with 10/10 -> done drops, result quotient=1, remainder=0.
- Pulse start high during CALC -> ignored, current result unchanged.
- Drive reset=0 mid-CALC -> busy=0, done=0, quotient=0 immediately without waiting for a clock edge. After release, IDLE waits for start.

Source files
------------

// File: rtl/div1_pkg.sv
// Shared state encoding and default width for the div1 repeated-subtraction divider.
package div1_pkg;

  localparam int DIV1_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    CALC = 3'd3,
    DONE = 3'd4
  } div1_state_t;

endpackage

// File: rtl/div1_dp.sv
// div1 datapath: remainder, divisor and quotient registers with compare/subtract/increment.
module div1_dp
  import div1_pkg::*;
#(
  parameter int WIDTH = DIV1_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_r,
  input  logic             load_d,
  input  logic             step,
  input  logic             sat_q,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic             ge,
  output logic             dz
);

  logic [WIDTH-1:0] d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
      d <= '0;
      q <= '0;
    end else begin
      if (load_r)
        r <= data_in;
      else if (step)
        r <= r - d;

      // loading the divisor starts a fresh quotient
      if (load_d) begin
        d <= data_in;
        q <= '0;
      end else if (sat_q) begin
        q <= '1;
      end else if (step) begin
        q <= q + WIDTH'(1);
      end
    end
  end

  assign ge = (r >= d);
  assign dz = (d == '0);

endmodule

// File: rtl/div1.sv
// div1: sequential unsigned divider by repeated subtraction.
// Optional divide-by-zero flag port enabled by defining DIV1_DBZ_EN.
//
// state | meaning
// IDLE  | waiting for start
// LDA   | capture dividend into R
// LDB   | capture divisor into D, clear Q
// CALC  | subtract D from R while R >= D, counting into Q
// DONE  | result held, done high until next start
module div1
  import div1_pkg::*;
#(
  parameter int WIDTH = DIV1_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV1_DBZ_EN
  ,
  output logic             div_by_zero
`endif
);

  div1_state_t state;
  logic load_r, load_d, step, sat_q;
  logic ge, dz;

  always_comb begin
    load_r = 1'b0;
    load_d = 1'b0;
    step   = 1'b0;
    sat_q  = 1'b0;
    case (state)
      LDA:  load_r = 1'b1;
      LDB:  load_d = 1'b1;
      CALC: begin
        sat_q = dz;
        step  = !dz && ge;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LDA;
            busy  <= 1'b1;
          end
        end
        LDA: begin
          state <= LDB;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        LDB: begin
          state <= CALC;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        CALC: begin
          if (dz || !ge) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= LDA;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV1_DBZ_EN
  // flag is captured on the CALC exit and only survives while DONE is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      div_by_zero <= 1'b0;
    else if (state == CALC)
      div_by_zero <= dz;
    else if (state == DONE && !start)
      div_by_zero <= div_by_zero;
    else
      div_by_zero <= 1'b0;
  end
`endif

  div1_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load_r  (load_r),
    .load_d  (load_d),
    .step    (step),
    .sat_q   (sat_q),
    .data_in (data_in),
    .r       (remainder),
    .q       (quotient),
    .ge      (ge),
    .dz      (dz)
  );

endmodule

// File: tb/tb_div1.sv
// Self-checking bench for div1: directed corner cases plus random operands against an arithmetic model.
module tb_div1;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
`ifdef DIV1_DBZ_EN
  logic        div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  div1 #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef DIV1_DBZ_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One division from the start pulse onward. pulse_at re-asserts start at that
  // cycle offset; rst_at pulls reset low at that offset and ends the operation.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input int pulse_at, input int rst_at, input string tag);
    int qe, re, lat, k;
    bit seen, busy_bad;
    if (b == 16'd0) begin
      qe  = 32'hFFFF;
      re  = int'(a);
      lat = 4;
    end else begin
      qe  = int'(a) / int'(b);
      re  = int'(a) % int'(b);
      lat = 4 + qe;
    end
    @(negedge clk);
    start = 1'b1;
    k = 0;
    seen = 1'b0;
    busy_bad = 1'b0;
    while (!seen && k < lat + 8) begin
      @(negedge clk);
      k++;
      start = (k == pulse_at);
      if (k == rst_at) begin
        #2 reset = 1'b0;
        #1;
        check({tag, " rst busy"}, 32'(busy), 32'd0);
        check({tag, " rst done"}, 32'(done), 32'd0);
        check({tag, " rst quotient"}, 32'(quotient), 32'd0);
        check({tag, " rst remainder"}, 32'(remainder), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
        return;
      end
      if (done) seen = 1'b1;
      else if (!busy) busy_bad = 1'b1;
      if (k == 1) data_in = a;
      else if (k == 2) data_in = b;
      else data_in = 16'($urandom);
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy window"}, 32'(busy_bad), 32'd0);
    check({tag, " quotient"}, 32'(quotient), 32'(qe));
    check({tag, " remainder"}, 32'(remainder), 32'(re));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
`ifdef DIV1_DBZ_EN
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(b == 16'd0));
`endif
    repeat (2) @(negedge clk);
    check({tag, " done held"}, 32'(done), 32'd1);
    check({tag, " quotient held"}, 32'(quotient), 32'(qe));
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
`ifdef DIV1_DBZ_EN
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);

    run_div(16'd100, 16'd7, 0, 0, "100/7");
    run_div(16'd5, 16'd9, 0, 0, "5/9");
    run_div(16'd9, 16'd0, 0, 0, "9/0");
    run_div(16'd0, 16'd3, 0, 0, "0/3");
    run_div(16'd65535, 16'd1, 0, 0, "65535/1");
    // restarted straight out of DONE: done must drop on the first cycle
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart done drops", 32'(done), 32'd0);
    check("restart busy", 32'(busy), 32'd1);
    data_in = 16'd10;
    @(negedge clk);
    data_in = 16'd10;
    repeat (6) @(negedge clk);
    check("10/10 done", 32'(done), 32'd1);
    check("10/10 quotient", 32'(quotient), 32'd1);
    check("10/10 remainder", 32'(remainder), 32'd0);

    run_div(16'd100, 16'd7, 7, 0, "start in CALC");
    run_div(16'd300, 16'd3, 0, 10, "reset in CALC");
    run_div(16'd44, 16'd5, 0, 0, "after reset");

    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 500));
      rb = 16'($urandom_range(0, 60));
      run_div(ra, rb, 0, 0, $sformatf("rand%0d %0d/%0d", i, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
